zx81_tape_saver: RTL and testbench
==================================

Name: zx81_tape_saver

Overview:
- Decodes the ZX81/ZX80 SAVE waveform (CPU-driven tape output level) into bytes and stores them in an internal 16 KB capture buffer.
- The host reads the buffer back through a registered read port and writes it out as a .p/.o image.
- Sits beside the tape loader and consumes the same 3.25 MHz clock enable as the sync generator.

Parameters:
- PULSE_MIN, 64: minimum high time in ce ticks for a valid pulse; shorter highs are glitches.
- GAP_TICKS, 1600: low time in ce ticks that terminates a bit (~490 us).
- END_TICKS, 325000: low time in ce ticks that terminates the file (~100 ms).
- BIT1_MIN, 6: minimum pulse count decoded as bit 1.
- SKIP_NAME, 1: 1 = discard leading filename bytes.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- ce  in  1  3.25 MHz tick enable
- tape_out  in  1  raw SAVE output level from the machine
- enable  in  1  capture armed
- save_ack  in  1  one-clk pulse that acknowledges done and returns to IDLE
- rd_addr  in  14  host read address
- rd_data  out  8  buffer byte; registered, 1 clk latency
- save_size  out  14  bytes captured
- save_busy  out  1  capture in progress
- save_done  out  1  file complete
- overflow  out  1  bytes were dropped because the buffer was full

Behaviour:
- Reset values:
  - save_size=0, save_busy=0, save_done=0, overflow=0, rd_data=0, state=IDLE.
  - All counters 0.
  - name_phase=SKIP_NAME.
- Input handling:
  - tape_out passes through a 2-flop synchroniser.
  - Level and edge evaluation happens only on ce ticks.
- Counters:
  - hi_cnt: 10 bits, saturating.
  - lo_cnt: 19 bits, saturating.
  - pulse_cnt: 4 bits, saturating at 15.
  - bit_cnt: 3 bits.
  - shift: 8 bits.
  - wr_addr: 15 bits, so the value 16384 is representable.
- IDLE:
  - On a rising edge with enable=1, go to HIGH.
  - Clear save_size, wr_addr, overflow, pulse_cnt and bit_cnt.
  - Set name_phase=SKIP_NAME and save_busy=1.
- HIGH:
  - Increment hi_cnt each tick.
  - On a falling edge:
    - If hi_cnt>=PULSE_MIN, increment pulse_cnt.
    - Otherwise ignore the pulse (glitch) and leave pulse_cnt unchanged.
  - Clear hi_cnt and go to LOW.
  - lo_cnt is cleared only after a valid pulse; after a glitch it resumes its count.
- LOW:
  - Increment lo_cnt each tick; a rising edge goes to HIGH.
  - When lo_cnt==GAP_TICKS and pulse_cnt!=0, resolve one bit, once per gap:
    - bit value = (pulse_cnt>=BIT1_MIN).
    - Shift MSB-first: shift={shift[6:0],bit}.
    - Increment bit_cnt and clear pulse_cnt.
  - A gap with pulse_cnt==0 resolves no bit.
  - When lo_cnt==END_TICKS, go to DONE:
    - save_busy=0, save_done=1.
    - A partial byte (bit_cnt!=0) is discarded.
- Byte completion (bit_cnt wraps 7->0), in the same clk as the 8th bit:
  - If name_phase=1: discard the byte. If byte[7]=1, clear name_phase (the last name char has bit 7 set).
  - Else if wr_addr<16384: write to buffer[wr_addr], increment wr_addr, save_size<=wr_addr+1 (14-bit truncation; 16384 reads as 0 while overflow stays valid).
  - Else: drop the byte and set overflow=1, sticky until next capture start.
- DONE:
  - Hold save_size and save_done until save_ack.
  - save_ack returns to IDLE and clears save_done.
  - save_ack outside DONE has no effect.
- enable deasserted in HIGH/LOW: abort to IDLE next clk.
  - save_busy=0; save_done stays 0.
  - save_size and the buffer keep their partial contents.
- Reset mid-capture: all state returns to reset values. Buffer contents are undefined but harmless.
- Read port:
  - rd_data is valid on the clk after rd_addr.
  - Available in every state.
  - A same-address write in the same clk returns the old data.
- The buffer is single-write / single-read dual-port RAM. Write happens only at byte completion.

Test Plan:
- SKIP_NAME=0, enable=1; send byte 0x41 as pulse trains 4,9,4,4,4,4,4,9 (487-tick high/low, 4225-tick gap), then 400000 low ticks -> save_size=1, buffer[0]=0x41, save_done=1, save_busy=0.
- SKIP_NAME=1; name bytes 0x26,0xA6 then data 0x00,0xFF -> save_size=2, buffer[0]=0x00, buffer[1]=0xFF.
- Insert 20-tick highs between valid pulses of a 4-pulse bit -> decoded as 0 (glitch not counted); a 9-pulse bit with glitches still decodes as 1.
- Stream 16385 bytes -> save_size=0 (wrapped), overflow=1, buffer[16383] equals the 16384th byte, the 16385th byte is absent.
- Drop enable after 3 bytes -> state IDLE, save_busy=0, save_done=0, save_size=3; re-arm and capture 1 byte -> save_size=1, overflow=0.
- In DONE, pulse save_ack -> save_done=0 next clk; send 5 bits then END gap -> save_size=0, save_done=1 (partial byte discarded).

Source files
------------

// File: rtl/zx81_tape_saver.sv
// -----------------------------------------------------------------------------
// zx81_tape_saver
//   Decodes the ZX81/ZX80 SAVE waveform into bytes and captures them in an
//   internal buffer. The host reads the buffer through a registered read port.
//
//   A bit is a train of high pulses followed by a long low gap. A train of
//   BIT1_MIN or more valid pulses is a 1, and a shorter train is a 0. Bits
//   arrive MSB first. A very long low ends the file. When SKIP_NAME is set,
//   the leading filename bytes are dropped. The last name character is the
//   one with bit 7 set.
//
// Ports
//   clk_sys    system clock
//   reset      synchronous, active-high
//   ce         tick enable; all level/edge evaluation happens on ce ticks
//   tape_out   raw SAVE output level from the machine (asynchronous)
//   enable     capture armed; dropping it mid-capture aborts to idle
//   save_ack   one-clk pulse; acknowledges a finished file
//   rd_addr    host read address
//   rd_data    buffer byte at rd_addr, one clk latency
//   save_size  number of bytes captured (wraps to 0 when the buffer is full)
//   save_busy  capture in progress
//   save_done  file complete, held until save_ack
//   overflow   bytes were dropped because the buffer was full
// -----------------------------------------------------------------------------
module zx81_tape_saver #(
  parameter int PULSE_MIN = 64,
  parameter int GAP_TICKS = 1600,
  parameter int END_TICKS = 325000,
  parameter int BIT1_MIN  = 6,
  parameter int SKIP_NAME = 1,
  parameter int ADDR_W    = 14
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce,
  input  logic              tape_out,
  input  logic              enable,
  input  logic              save_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] save_size,
  output logic              save_busy,
  output logic              save_done,
  output logic              overflow
);

  // state  | meaning
  // IDLE   | waiting for the first rising edge while armed
  // HIGH   | tape level high, timing a pulse
  // LOW    | tape level low, timing the gap after a pulse
  // DONE   | end-of-file gap seen, holding results until save_ack
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int              DEPTH       = 1 << ADDR_W;
  localparam logic [9:0]      PULSE_MIN_C = 10'(PULSE_MIN);
  localparam logic [18:0]     GAP_C       = 19'(GAP_TICKS);
  localparam logic [18:0]     END_C       = 19'(END_TICKS);
  localparam logic [3:0]      BIT1_C      = 4'(BIT1_MIN);
  localparam logic            NAME_INIT   = (SKIP_NAME != 0);
  localparam logic [ADDR_W:0] WR_ONE      = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q, prev_q;
  logic [9:0]        hi_cnt_q, hi_cnt_d;
  logic [18:0]       lo_cnt_q, lo_cnt_d;
  logic [3:0]        pulse_cnt_q, pulse_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] save_size_q, save_size_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              name_phase_q, name_phase_d;
  logic [7:0]        rd_data_q;

  logic              tick_rise, tick_fall;
  logic [9:0]        hi_inc;
  logic [18:0]       lo_inc;
  logic [3:0]        pulse_inc;
  logic              new_bit;
  logic [7:0]        new_byte;
  logic              wr_en;
  logic [7:0]        wr_data;

  logic [7:0]        mem_q [DEPTH];

  assign tick_rise = ce &  sync2_q & ~prev_q;
  assign tick_fall = ce & ~sync2_q &  prev_q;

  assign hi_inc    = (&hi_cnt_q)    ? hi_cnt_q    : hi_cnt_q    + 10'd1;
  assign lo_inc    = (&lo_cnt_q)    ? lo_cnt_q    : lo_cnt_q    + 19'd1;
  assign pulse_inc = (&pulse_cnt_q) ? pulse_cnt_q : pulse_cnt_q + 4'd1;

  assign new_bit   = (pulse_cnt_q >= BIT1_C);
  assign new_byte  = {shift_q[6:0], new_bit};

  always_comb begin
    state_d      = state_q;
    hi_cnt_d     = hi_cnt_q;
    lo_cnt_d     = lo_cnt_q;
    pulse_cnt_d  = pulse_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    wr_addr_d    = wr_addr_q;
    save_size_d  = save_size_q;
    busy_d       = busy_q;
    done_d       = done_q;
    ovf_d        = ovf_q;
    name_phase_d = name_phase_q;
    wr_en        = 1'b0;
    wr_data      = new_byte;

    case (state_q)
      S_IDLE: begin
        if (tick_rise && enable) begin
          state_d      = S_HIGH;
          hi_cnt_d     = '0;
          lo_cnt_d     = '0;
          pulse_cnt_d  = '0;
          bit_cnt_d    = '0;
          shift_d      = '0;
          wr_addr_d    = '0;
          save_size_d  = '0;
          ovf_d        = 1'b0;
          name_phase_d = NAME_INIT;
          busy_d       = 1'b1;
        end
      end

      S_HIGH: begin
        if (!enable) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (ce) begin
          if (tick_fall) begin
            // A glitch leaves lo_cnt alone so the gap timer resumes.
            if (hi_cnt_q >= PULSE_MIN_C) begin
              pulse_cnt_d = pulse_inc;
              lo_cnt_d    = '0;
            end
            hi_cnt_d = '0;
            state_d  = S_LOW;
          end else begin
            hi_cnt_d = hi_inc;
          end
        end
      end

      S_LOW: begin
        if (!enable) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (ce) begin
          if (tick_rise) begin
            state_d = S_HIGH;
          end else begin
            lo_cnt_d = lo_inc;
            // Equality means each gap resolves at most one bit.
            if (lo_inc == GAP_C && pulse_cnt_q != 4'd0) begin
              shift_d     = new_byte;
              bit_cnt_d   = bit_cnt_q + 3'd1;
              pulse_cnt_d = '0;
              if (bit_cnt_q == 3'd7) begin
                if (name_phase_q) begin
                  if (new_byte[7]) name_phase_d = 1'b0;
                end else if (!wr_addr_q[ADDR_W]) begin
                  wr_en       = 1'b1;
                  wr_addr_d   = wr_addr_q + WR_ONE;
                  // A full buffer wraps the count to 0, which is why
                  // overflow is a separate flag.
                  save_size_d = wr_addr_d[ADDR_W-1:0];
                end else begin
                  ovf_d = 1'b1;
                end
              end
            end
            if (lo_inc == END_C) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end

      S_DONE: begin
        if (save_ack) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      hi_cnt_q     <= '0;
      lo_cnt_q     <= '0;
      pulse_cnt_q  <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      wr_addr_q    <= '0;
      save_size_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      name_phase_q <= NAME_INIT;
    end else begin
      state_q      <= state_d;
      sync1_q      <= tape_out;
      sync2_q      <= sync1_q;
      if (ce) prev_q <= sync2_q;
      hi_cnt_q     <= hi_cnt_d;
      lo_cnt_q     <= lo_cnt_d;
      pulse_cnt_q  <= pulse_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      wr_addr_q    <= wr_addr_d;
      save_size_q  <= save_size_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      name_phase_q <= name_phase_d;
    end
  end

  // Capture buffer. A same-address read and write in one clk return the old
  // byte.
  always_ff @(posedge clk_sys) begin
    if (wr_en && !reset) mem_q[wr_addr_q[ADDR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) rd_data_q <= 8'd0;
    else       rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data   = rd_data_q;
  assign save_size = save_size_q;
  assign save_busy = busy_q;
  assign save_done = done_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_zx81_tape_saver.sv
// -----------------------------------------------------------------------------
// tb_zx81_tape_saver
//   Two saver instances share one stimulus stream. u0 keeps every byte, and
//   u1 skips the filename. Timing parameters are scaled down and the buffer
//   holds 16 bytes, so that overflow can be reached in a short run. A
//   reference model driven by run lengths predicts every output on every
//   clk. Literal checks at the end of each scenario compare the buffer
//   against the bytes that were sent.
// -----------------------------------------------------------------------------
module tb_zx81_tape_saver;

  localparam int PM    = 4;
  localparam int GAP   = 12;
  localparam int ENDT  = 60;
  localparam int B1    = 6;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk_sys = 1'b0;
  logic          reset, ce, tape_out, enable, save_ack;
  logic [AW-1:0] rd_addr;
  logic [7:0]    d_rd   [2];
  logic [AW-1:0] d_size [2];
  logic          d_busy [2];
  logic          d_done [2];
  logic          d_ovf  [2];

  int checks = 0;
  int errors = 0;
  bit hold_rd = 1'b0;

  always #5 clk_sys = ~clk_sys;

  zx81_tape_saver #(.PULSE_MIN(PM), .GAP_TICKS(GAP), .END_TICKS(ENDT),
                    .BIT1_MIN(B1), .SKIP_NAME(0), .ADDR_W(AW)) u0 (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .tape_out(tape_out),
    .enable(enable), .save_ack(save_ack), .rd_addr(rd_addr),
    .rd_data(d_rd[0]), .save_size(d_size[0]), .save_busy(d_busy[0]),
    .save_done(d_done[0]), .overflow(d_ovf[0]));

  zx81_tape_saver #(.PULSE_MIN(PM), .GAP_TICKS(GAP), .END_TICKS(ENDT),
                    .BIT1_MIN(B1), .SKIP_NAME(1), .ADDR_W(AW)) u1 (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .tape_out(tape_out),
    .enable(enable), .save_ack(save_ack), .rd_addr(rd_addr),
    .rd_data(d_rd[1]), .save_size(d_size[1]), .save_busy(d_busy[1]),
    .save_done(d_done[1]), .overflow(d_ovf[1]));

  task automatic chk(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors < 40)
        $display("FAIL %s[u%0d] at %0t: actual 0x%0h required 0x%0h", nm, k, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  // The model watches the samples seen on ce ticks after the two-clk delay,
  // measures the high and low run lengths, and builds bytes from the pulse
  // counts.
  bit  model_init = 1'b0;
  bit  m_s1, m_s2, m_prev;
  int  m_mode   [2];        // 0 waiting, 1 capturing, 2 file finished
  bit  m_inhigh [2];
  int  m_hi [2], m_lo [2], m_pulses [2], m_bits [2], m_acc [2], m_wr [2];
  int  m_size [2];
  bit  m_busy [2], m_done [2], m_ovf [2], m_name [2];
  int  mem  [2][DEPTH];
  bit  memv [2][DEPTH];
  int  m_rd [2];
  bit  m_rdv [2];

  task automatic model_bit(input int k);
    int b;
    int v;
    b = (m_pulses[k] >= B1) ? 1 : 0;
    m_acc[k] = ((m_acc[k] * 2) + b) % 256;
    m_pulses[k] = 0;
    m_bits[k]++;
    if (m_bits[k] == 8) begin
      m_bits[k] = 0;
      v = m_acc[k];
      if (m_name[k]) begin
        if (v >= 128) m_name[k] = 1'b0;
      end else if (m_wr[k] < DEPTH) begin
        mem[k][m_wr[k]]  = v;
        memv[k][m_wr[k]] = 1'b1;
        m_wr[k]++;
        m_size[k] = m_wr[k] % DEPTH;
      end else begin
        m_ovf[k] = 1'b1;
      end
    end
  endtask

  always @(posedge clk_sys) begin : model
    bit samp, rise, fall;
    samp = m_s2;
    rise = ce &&  samp && !m_prev;
    fall = ce && !samp &&  m_prev;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_prev = 0;
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = 0; m_inhigh[k] = 0; m_hi[k] = 0; m_lo[k] = 0;
        m_pulses[k] = 0; m_bits[k] = 0; m_acc[k] = 0; m_wr[k] = 0;
        m_size[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_ovf[k] = 0;
        m_name[k] = (k == 1);
        m_rd[k] = 0; m_rdv[k] = 1;
        for (int a = 0; a < DEPTH; a++) memv[k][a] = 0;
      end
      model_init = 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_rdv[k] = memv[k][rd_addr];
        m_rd[k]  = mem[k][rd_addr];
        if (m_mode[k] == 0) begin
          if (rise && enable) begin
            m_mode[k] = 1; m_inhigh[k] = 1; m_hi[k] = 0; m_lo[k] = 0;
            m_pulses[k] = 0; m_bits[k] = 0; m_acc[k] = 0; m_wr[k] = 0;
            m_size[k] = 0; m_ovf[k] = 0; m_name[k] = (k == 1); m_busy[k] = 1;
          end
        end else if (m_mode[k] == 1) begin
          if (!enable) begin
            m_mode[k] = 0; m_busy[k] = 0;
          end else if (ce) begin
            if (m_inhigh[k]) begin
              if (fall) begin
                if (m_hi[k] >= PM) begin
                  m_pulses[k] = (m_pulses[k] < 15) ? m_pulses[k] + 1 : 15;
                  m_lo[k] = 0;
                end
                m_hi[k] = 0;
                m_inhigh[k] = 0;
              end else begin
                m_hi[k] = (m_hi[k] < 1023) ? m_hi[k] + 1 : 1023;
              end
            end else if (rise) begin
              m_inhigh[k] = 1;
            end else begin
              m_lo[k] = (m_lo[k] < 524287) ? m_lo[k] + 1 : 524287;
              if (m_lo[k] == GAP && m_pulses[k] != 0) model_bit(k);
              if (m_lo[k] == ENDT) begin
                m_mode[k] = 2; m_busy[k] = 0; m_done[k] = 1;
              end
            end
          end
        end else if (save_ack) begin
          m_mode[k] = 0; m_done[k] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = tape_out;
      if (ce) m_prev = samp;
    end
  end

  always @(negedge clk_sys) begin
    if (model_init) begin
      for (int k = 0; k < 2; k++) begin
        chk("save_size", k, int'(d_size[k]), m_size[k]);
        chk("save_busy", k, int'(d_busy[k]), int'(m_busy[k]));
        chk("save_done", k, int'(d_done[k]), int'(m_done[k]));
        chk("overflow",  k, int'(d_ovf[k]),  int'(m_ovf[k]));
        if (m_rdv[k]) chk("rd_data", k, int'(d_rd[k]), m_rd[k]);
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    ce = 1'b0;
    rd_addr = '0;
    forever begin
      @(negedge clk_sys);
      ce = ($urandom_range(0, 2) != 0);
      if (!hold_rd) rd_addr = AW'($urandom_range(0, DEPTH - 1));
    end
  end

  // Holds the tape level for n ce ticks.
  task automatic put(input bit lvl, input int n);
    int cnt;
    @(negedge clk_sys);
    tape_out = lvl;
    cnt = 0;
    while (cnt < n) begin
      @(posedge clk_sys);
      if (ce) cnt++;
    end
  endtask

  task automatic send_bit(input bit b, input bit glitchy, input bit fixed);
    int n;
    if (fixed) n = b ? 9 : 4;
    else       n = b ? int'($urandom_range(6, 10)) : int'($urandom_range(1, 4));
    for (int i = 0; i < n; i++) begin
      put(1'b1, int'($urandom_range(8, 10)));
      put(1'b0, int'($urandom_range(4, 6)));
      if (glitchy && i < n - 1) begin
        put(1'b1, 1);
        put(1'b0, int'($urandom_range(4, 6)));
      end
    end
    put(1'b0, GAP + 5);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit glitchy, input bit fixed);
    if ($urandom_range(0, 3) == 0) begin
      // An ack outside the finished state must do nothing.
      @(negedge clk_sys); save_ack = 1'b1;
      @(negedge clk_sys); save_ack = 1'b0;
    end
    for (int i = 7; i >= 0; i--) send_bit(v[i], glitchy, fixed);
  endtask

  task automatic end_file();
    put(1'b0, ENDT + 5);
    @(negedge clk_sys);
  endtask

  task automatic pulse_ack();
    @(negedge clk_sys); save_ack = 1'b1;
    @(negedge clk_sys); save_ack = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input int k, input int a, input int exp);
    hold_rd = 1'b1;
    @(negedge clk_sys);
    rd_addr = AW'(a);
    @(negedge clk_sys);
    chk(nm, k, int'(d_rd[k]), exp);
    hold_rd = 1'b0;
  endtask

  logic [7:0] sent [17];

  initial begin
    reset = 1'b1; enable = 1'b0; tape_out = 1'b0; save_ack = 1'b0;
    repeat (4) @(negedge clk_sys);
    for (int k = 0; k < 2; k++) begin
      chk("reset_size", k, int'(d_size[k]), 0);
      chk("reset_busy", k, int'(d_busy[k]), 0);
      chk("reset_done", k, int'(d_done[k]), 0);
      chk("reset_ovf",  k, int'(d_ovf[k]),  0);
      chk("reset_rd",   k, int'(d_rd[k]),   0);
    end
    reset = 1'b0;

    // One byte 0x41 as fixed 4/9-pulse trains.
    enable = 1'b1;
    put(1'b0, 10);
    send_byte(8'h41, 1'b0, 1'b1);
    end_file();
    chk("t1_size", 0, int'(d_size[0]), 1);
    chk("t1_done", 0, int'(d_done[0]), 1);
    chk("t1_busy", 0, int'(d_busy[0]), 0);
    chk("t1_size_skip", 1, int'(d_size[1]), 0);
    rd_chk("t1_buf0", 0, 0, 8'h41);
    pulse_ack();

    // Name 0x26,0xA6 then data 0x00,0xFF.
    put(1'b0, 5);
    send_byte(8'h26, 1'b0, 1'b0);
    send_byte(8'hA6, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    end_file();
    chk("t2_size", 1, int'(d_size[1]), 2);
    chk("t2_size_all", 0, int'(d_size[0]), 4);
    rd_chk("t2_buf0", 1, 0, 8'h00);
    rd_chk("t2_buf1", 1, 1, 8'hFF);
    rd_chk("t2_buf1_all", 0, 1, 8'hA6);
    pulse_ack();

    // Glitches between the valid pulses of every bit.
    put(1'b0, 5);
    send_byte(8'h55, 1'b1, 1'b1);
    end_file();
    chk("t3_size", 0, int'(d_size[0]), 1);
    rd_chk("t3_buf0", 0, 0, 8'h55);
    pulse_ack();

    // Overflow: 17 bytes into a 16-byte buffer.
    for (int i = 0; i < 17; i++) sent[i] = 8'($urandom_range(0, 255));
    sent[0]  = sent[0] | 8'h80;
    sent[16] = ~sent[15];
    put(1'b0, 5);
    for (int i = 0; i < 17; i++) send_byte(sent[i], 1'b0, 1'b0);
    end_file();
    chk("t4_size", 0, int'(d_size[0]), 0);
    chk("t4_ovf",  0, int'(d_ovf[0]),  1);
    chk("t4_size_skip", 1, int'(d_size[1]), 0);
    chk("t4_ovf_skip",  1, int'(d_ovf[1]),  0);
    rd_chk("t4_buf0",  0, 0,  int'(sent[0]));
    rd_chk("t4_buf15", 0, 15, int'(sent[15]));
    rd_chk("t4_buf15_skip", 1, 15, int'(sent[16]));
    pulse_ack();

    // Abort after three bytes, then re-arm.
    put(1'b0, 5);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    put(1'b0, 3);
    @(negedge clk_sys); enable = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("t5_busy", 0, int'(d_busy[0]), 0);
    chk("t5_done", 0, int'(d_done[0]), 0);
    chk("t5_size", 0, int'(d_size[0]), 3);
    enable = 1'b1;
    put(1'b0, 5);
    send_byte(8'h3C, 1'b0, 1'b0);
    end_file();
    chk("t5_resize", 0, int'(d_size[0]), 1);
    chk("t5_ovf",    0, int'(d_ovf[0]),  0);
    chk("t5_redone", 0, int'(d_done[0]), 1);
    rd_chk("t5_buf0", 0, 0, 8'h3C);

    // Ack, then a partial byte followed by the end gap.
    pulse_ack();
    chk("t6_ack_done", 0, int'(d_done[0]), 0);
    put(1'b0, 5);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end_file();
    chk("t6_size", 0, int'(d_size[0]), 0);
    chk("t6_done", 0, int'(d_done[0]), 1);
    chk("t6_busy", 0, int'(d_busy[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: run did not complete within 90000 cycles");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
